// File: rtl/i2c_slave.sv
// I2C target serving a DEPTH x 8 register file: pointer write, auto-increment burst write/read.
// Optional macro GENERAL_CALL_EN: ACK general call (7'h00, write), pulse gc_pulse, discard its data.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  localparam int        PTR_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             s_sda_i,
  output logic             s_sda_o,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
`ifdef GENERAL_CALL_EN
  output logic             gc_pulse,
`endif
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  state_t           state, state_next;
  logic             scl_p0, scl_p1, scl_p2;
  logic             sda_p0, sda_p1, sda_p2;
  logic             scl_rise, scl_fall, start_ev, stop_ev, byte_done;
  logic [7:0]       regs [DEPTH];
  logic [7:0]       shift;
  logic [3:0]       bit_cnt;
  logic [PTR_W-1:0] ptr, ptr_inc;
  logic             first_byte, gc_mode, gc_hit, addr_hit;

  // p0/p1: two-flop synchronizers; p2: history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_p0, scl_p1, scl_p2} <= 3'b111;
      {sda_p0, sda_p1, sda_p2} <= 3'b111;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= s_sda_i;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_ev  = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_ev   = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign byte_done = scl_fall && (bit_cnt == 4'd8);
  assign ptr_inc   = ptr + 1'b1;
`ifdef GENERAL_CALL_EN
  assign gc_hit    = (shift == 8'h00);
`else
  assign gc_hit    = 1'b0;
`endif
  assign addr_hit  = (shift[7:1] == SLAVE_ADDR) || gc_hit;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // START/STOP override every state so a bus event always resynchronises the target
  always_comb begin
    state_next = state;
    if (stop_ev) begin
      state_next = IDLE;
    end else if (start_ev) begin
      state_next = ADDR;
    end else begin
      case (state)
        ADDR:     if (byte_done) state_next = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall)  state_next = shift[0] ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (byte_done) state_next = WR_ACK;
        WR_ACK:   if (scl_fall)  state_next = WR_BYTE;
        RD_BYTE:  if (byte_done) state_next = RD_ACK;
        RD_ACK:   if (scl_rise)  state_next = sda_p1 ? WAIT_STOP : RD_BYTE;
        default:  state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_sda_o    <= 1'b1;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      ptr        <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      first_byte <= 1'b0;
      gc_mode    <= 1'b0;
`ifdef GENERAL_CALL_EN
      gc_pulse   <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
`ifdef GENERAL_CALL_EN
      gc_pulse  <= 1'b0;
`endif
      if (stop_ev) begin
        s_sda_o <= 1'b1;
      end else if (start_ev) begin
        s_sda_o <= 1'b1;
        bit_cnt <= '0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_p1};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (byte_done) begin
              s_sda_o    <= ~addr_hit;
              first_byte <= 1'b1;
              gc_mode    <= gc_hit;
`ifdef GENERAL_CALL_EN
              gc_pulse   <= gc_hit;
`endif
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (shift[0]) begin
                // first read bit goes out on the same fall that ends the address ACK
                s_sda_o <= regs[ptr][7];
                shift   <= {regs[ptr][6:0], 1'b0};
                bit_cnt <= 4'd1;
              end else begin
                s_sda_o <= 1'b1;
                bit_cnt <= '0;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_p1};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (byte_done) begin
              s_sda_o    <= 1'b0;
              first_byte <= 1'b0;
              if (!gc_mode) begin
                if (first_byte) begin
                  ptr <= shift[PTR_W-1:0];
                end else begin
                  regs[ptr] <= shift;
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                  wr_data   <= shift;
                  ptr       <= ptr_inc;
                end
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              s_sda_o <= 1'b1;
              bit_cnt <= '0;
            end
          end
          RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                s_sda_o <= 1'b1;
              end else begin
                s_sda_o <= shift[7];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && !sda_p1) begin
              ptr     <= ptr_inc;
              shift   <= regs[ptr_inc];
              bit_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master with a transaction-level register-file model.
`timescale 1ns/1ps
module tb_i2c_slave;
  localparam logic [6:0] SLAVE = 7'h50;
  localparam int DEPTH = 16;
  localparam int Q = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic s_sda_o, wr_strobe, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
`ifdef GENERAL_CALL_EN
  logic gc_pulse;
`endif
  wire sda_bus = sda_m & s_sda_o;

  i2c_slave #(.SLAVE_ADDR(SLAVE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .s_sda_i(sda_bus), .s_sda_o(s_sda_o),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef GENERAL_CALL_EN
    .gc_pulse(gc_pulse),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  int tests = 0, failed = 0, cyc = 0, quiet_until = 0, gc_seen = 0, gc_exp = 0;
  bit run = 0, exp_busy = 0, exp_release = 0;
  logic [7:0] mregs [DEPTH];
  int mptr = 0;
  bit tx_match, tx_rw, tx_gc, tx_first;
  logic [11:0] expq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic s);
    tick(Q); sda_m = b;
    tick(Q); scl_m = 1'b1;
    tick(Q); s = sda_bus;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic m_start();
    tick(Q); sda_m = 1'b1;
    tick(Q); scl_m = 1'b1;
    tick(2*Q);
    sda_m = 1'b0; quiet_until = cyc + 8; exp_busy = 1; exp_release = 0;
    tick(2*Q); scl_m = 1'b0;
  endtask

  task automatic m_stop();
    tick(Q); sda_m = 1'b0;
    tick(Q); scl_m = 1'b1;
    tick(2*Q);
    sda_m = 1'b1; quiet_until = cyc + 8; exp_busy = 0; exp_release = 0;
    tick(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, ack);
  endtask

  task automatic m_addr(input logic [6:0] a, input logic rw, output logic ack);
    tx_gc = 0;
`ifdef GENERAL_CALL_EN
    tx_gc = (a == 7'h00) && !rw;
`endif
    tx_match = (a == SLAVE) || tx_gc;
    tx_rw = rw;
    tx_first = 1;
    if (tx_gc) gc_exp++;
    send_byte({a, rw}, ack);
    chk("addr_ack", ack, tx_match ? 0 : 1);
    if (!tx_match) exp_release = 1;
  endtask

  task automatic m_wbyte(input logic [7:0] b, output logic ack);
    bit ok = tx_match && !tx_rw;
    if (ok && !tx_gc) begin
      if (tx_first) mptr = b % DEPTH;
      else begin
        expq.push_back({mptr[3:0], b});
        mregs[mptr] = b;
        mptr = (mptr + 1) % DEPTH;
      end
    end
    tx_first = 0;
    send_byte(b, ack);
    chk("wr_ack", ack, ok ? 0 : 1);
  endtask

  task automatic m_rbyte(input logic mack, output logic [7:0] got);
    logic s;
    logic [7:0] exp;
    exp = mregs[mptr];
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      got[i] = s;
    end
    chk("rd_data", got, exp);
    if (!mack) mptr = (mptr + 1) % DEPTH;
    bit_io(mack, s);
  endtask

  task automatic m_abort(input int nbits);
    logic s;
    for (int i = 0; i < nbits; i++) bit_io(1'($urandom_range(0, 1)), s);
    m_stop();
  endtask

  // per-cycle compare against the model's expected write stream and bus state
  always @(negedge clk) begin
    logic [11:0] e;
    cyc = cyc + 1;
    if (run) begin
      if (wr_strobe) begin
        chk("strobe_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("wr_addr", wr_addr, e[11:8]);
          chk("wr_data", wr_data, e[7:0]);
        end
      end
      if (cyc >= quiet_until) begin
        chk("busy", busy, exp_busy);
        if (exp_release) chk("sda_released", s_sda_o, 1);
      end
`ifdef GENERAL_CALL_EN
      if (gc_pulse) gc_seen++;
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic ack;
    int kind, n;
    logic [6:0] a;
    foreach (mregs[i]) mregs[i] = 8'h00;

    tick(5);
    chk("rst_sda_o", s_sda_o, 1);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick(4);
    run = 1;

    // register file and pointer start cleared
    m_start(); m_addr(SLAVE, 1'b1, ack); m_rbyte(1'b1, got);
    chk("lit_reset_reg0", got, 8'h00); m_stop();

    // burst write then read back via repeated START
    m_start(); m_addr(SLAVE, 1'b0, ack);
    m_wbyte(8'h03, ack); m_wbyte(8'hAA, ack); m_wbyte(8'h55, ack); m_stop();
    m_start(); m_addr(SLAVE, 1'b0, ack); m_wbyte(8'h03, ack);
    m_start(); m_addr(SLAVE, 1'b1, ack);
    m_rbyte(1'b0, got); chk("lit_rd_aa", got, 8'hAA);
    m_rbyte(1'b1, got); chk("lit_rd_55", got, 8'h55);
    m_stop();
    tick(12);
    chk("lit_busy_after_stop", busy, 0);

    // wrong address is ignored
    m_start(); m_addr(7'h51, 1'b0, ack); chk("lit_wrong_addr_nack", ack, 1);
    m_wbyte(8'h99, ack); m_stop();

    // pointer and data wrap
    m_start(); m_addr(SLAVE, 1'b0, ack); m_wbyte(8'h01, ack); m_wbyte(8'h5A, ack); m_stop();
    m_start(); m_addr(SLAVE, 1'b0, ack);
    m_wbyte(8'h0F, ack); m_wbyte(8'h11, ack); m_wbyte(8'h22, ack); m_stop();
    m_start(); m_addr(SLAVE, 1'b1, ack); m_rbyte(1'b1, got);
    chk("lit_ptr_after_wrap", got, 8'h5A); m_stop();
    m_start(); m_addr(SLAVE, 1'b0, ack); m_wbyte(8'h0F, ack);
    m_start(); m_addr(SLAVE, 1'b1, ack);
    m_rbyte(1'b0, got); chk("lit_reg15", got, 8'h11);
    m_rbyte(1'b0, got); chk("lit_reg0", got, 8'h22);
    m_rbyte(1'b1, got); chk("lit_reg1", got, 8'h5A);
    m_stop();

    // partial data byte cut short by STOP
    m_start(); m_addr(SLAVE, 1'b0, ack); m_wbyte(8'h03, ack); m_abort(4);
    m_start(); m_addr(SLAVE, 1'b1, ack); m_rbyte(1'b1, got);
    chk("lit_abort_reg3", got, 8'hAA); m_stop();

    // general call
    m_start(); m_addr(7'h00, 1'b0, ack);
`ifdef GENERAL_CALL_EN
    chk("lit_gc_addr_ack", ack, 0);
`else
    chk("lit_gc_addr_nack", ack, 1);
`endif
    m_wbyte(8'h7E, ack); m_stop();

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 5);
      case (kind)
        0: begin
          a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLAVE;
          m_start(); m_addr(a, 1'b0, ack);
          for (int i = 0; i < n; i++) m_wbyte(8'($urandom_range(0, 255)), ack);
          m_stop();
        end
        1: begin
          m_start(); m_addr(SLAVE, 1'b0, ack); m_wbyte(8'($urandom_range(0, 255)), ack);
          m_start(); m_addr(SLAVE, 1'b1, ack);
          for (int i = 0; i < n; i++) m_rbyte((i == n - 1), got);
          m_stop();
        end
        2: begin
          m_start(); m_addr(SLAVE, 1'b1, ack);
          for (int i = 0; i < n; i++) m_rbyte((i == n - 1), got);
          m_stop();
        end
        default: begin
          m_start(); m_addr(SLAVE, 1'b0, ack);
          if (n > 2) m_wbyte(8'($urandom_range(0, 255)), ack);
          m_abort($urandom_range(1, 7));
        end
      endcase
    end

    tick(20);
    chk("exp_queue_drained", expq.size(), 0);
`ifdef GENERAL_CALL_EN
    chk("gc_pulse_count", gc_seen, gc_exp);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
